// File: rtl/curve_buffer_ctrl_if.sv
// Handshake and buffer-port bundle between the VGA timing/curve source side and curve_buffer_ctrl.
// master drives timing counters and samples; slave (the controller) drives buffer writes and status.
interface curve_buffer_ctrl_if;
    logic [9:0] horizontalCount;
    logic [9:0] verticalCount;
    logic       captureReq;
    logic       captureAbort;
    logic [7:0] curveData;
    logic       sampleValid;
    logic       sampleReady;
    logic       wrEn;
    logic [9:0] wrAddr;
    logic [7:0] wrData;
    logic [9:0] rdAddr;
    logic       busy;
    logic       frameDone;

    modport master (
        output horizontalCount, verticalCount, captureReq, captureAbort, curveData, sampleValid,
        input  sampleReady, wrEn, wrAddr, wrData, rdAddr, busy, frameDone
    );

    modport slave (
        input  horizontalCount, verticalCount, captureReq, captureAbort, curveData, sampleValid,
        output sampleReady, wrEn, wrAddr, wrData, rdAddr, busy, frameDone
    );
endinterface

// File: rtl/curve_buffer_ctrl.sv
// Loads one frame of H_ACTIVE curve samples into the dot-position buffer during vertical blanking (build macro CURVE_CLAMP_EN clamps samples to CLAMP_MAX).
// Latency: wrEn/wrAddr/wrData and rdAddr are registered, 1 cycle after the accepting falling edge.
// Backpressure: sampleReady is high only while filling; loading pauses across active lines and resumes next blanking.
module curve_buffer_ctrl #(
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480,
    parameter int CLAMP_MAX = 239
) (
    input  logic               Clk,
    input  logic               vgaRes,
    curve_buffer_ctrl_if.slave bus
);
    localparam logic [9:0] H_LIM  = 10'(H_ACTIVE);
    localparam logic [9:0] H_LAST = 10'(H_ACTIVE - 1);
    localparam logic [9:0] V_LIM  = 10'(V_ACTIVE);

    typedef enum logic [2:0] {IDLE, ARM, FILL, PAUSE, DONE} state_t;

    state_t     state;
    state_t     state_nxt;
    logic [9:0] index;
    logic       xfer;
    logic       last;
    logic       blank_start;
    logic       active_line;
    logic [7:0] sample_val;

    logic       ready;
    logic       busy_st;
    logic       done_st;
    logic       wr_en;
    logic [9:0] wr_addr;
    logic [7:0] wr_data;
    logic [9:0] rd_addr;

    assign blank_start = (bus.verticalCount == V_LIM) && (bus.horizontalCount == 10'd0);
    assign active_line = (bus.verticalCount < V_LIM);
    // Abort takes priority over any sample offered on the same edge.
    assign xfer        = (state == FILL) && bus.sampleValid && !bus.captureAbort;
    assign last        = (index == H_LAST);

`ifdef CURVE_CLAMP_EN
    localparam logic [7:0] CLAMP_V = 8'(CLAMP_MAX);
    assign sample_val = (bus.curveData > CLAMP_V) ? CLAMP_V : bus.curveData;
`else
    logic [7:0] unused_clamp;
    assign unused_clamp = 8'(CLAMP_MAX);
    assign sample_val   = bus.curveData;
`endif

    always_ff @(negedge Clk or negedge vgaRes) begin
        if (!vgaRes) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (bus.captureAbort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (bus.captureReq) state_nxt = ARM;
                ARM:     if (blank_start) state_nxt = FILL;
                // The final sample wins over blanking ending on the same edge.
                FILL: begin
                    if (xfer && last) begin
                        state_nxt = DONE;
                    end else if (active_line) begin
                        state_nxt = PAUSE;
                    end
                end
                PAUSE:   if (blank_start) state_nxt = FILL;
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        ready   = 1'b0;
        busy_st = 1'b1;
        done_st = 1'b0;
        case (state)
            IDLE:    busy_st = 1'b0;
            FILL:    ready   = 1'b1;
            DONE:    done_st = 1'b1;
            default: ;
        endcase
    end

    always_ff @(negedge Clk or negedge vgaRes) begin
        if (!vgaRes) begin
            index   <= 10'd0;
            wr_en   <= 1'b0;
            wr_addr <= 10'd0;
            wr_data <= 8'd0;
            rd_addr <= 10'd0;
        end else begin
            wr_en   <= xfer;
            rd_addr <= (bus.horizontalCount < H_LIM) ? bus.horizontalCount : 10'd0;
            if (xfer) begin
                wr_addr <= index;
                wr_data <= sample_val;
            end
            if (bus.captureAbort) begin
                index <= 10'd0;
            end else if (xfer) begin
                index <= last ? 10'd0 : index + 10'd1;
            end
        end
    end

    assign bus.sampleReady = ready;
    assign bus.busy        = busy_st;
    assign bus.frameDone   = done_st;
    assign bus.wrEn        = wr_en;
    assign bus.wrAddr      = wr_addr;
    assign bus.wrData      = wr_data;
    assign bus.rdAddr      = rd_addr;
endmodule
